// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: round count, RCON table, S-box,
// FSM state encoding and the round-key type.
package aes_key_pkg;

   localparam int NR       = 10;
   localparam int NUM_KEYS = NR + 1;

   typedef logic [127:0] round_key_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Round constants indexed by round number 1..10; entry 0 is unused.
   localparam logic [7:0] RCON [NUM_KEYS] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] get_rcon(input logic [3:0] r);
      return (r <= 4'd10) ? RCON[r] : 8'h00;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Bus between the key loader / cipher rounds (master) and the key-schedule
// controller (slave): start handshake, key stream and round-key read port.
interface key_schedule_ctrl_if
   import aes_key_pkg::*;
#(
   parameter int AW = 4
) ();

   logic          start;
   round_key_t    key_in;
   logic          busy;
   logic          done;
   logic          key_valid;
   round_key_t    rk_out;
   logic          rk_out_vld;
   logic [3:0]    rk_out_idx;
   logic [AW-1:0] rd_addr;
   round_key_t    rd_data;

   modport master (
      output start, key_in, rd_addr,
      input  busy, done, key_valid, rk_out, rk_out_vld, rk_out_idx, rd_data
   );

   modport slave (
      input  start, key_in, rd_addr,
      output busy, done, key_valid, rk_out, rk_out_vld, rk_out_idx, rd_data
   );

endinterface

// File: rtl/key_round_comb.sv
// One AES-128 key-expansion step, purely combinational: previous round key
// and round number in, next round key out.
module key_round_comb
   import aes_key_pkg::*;
(
   input  round_key_t prev_key,
   input  logic [3:0] round,
   output round_key_t next_key
);

   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   // Word-chained XOR expansion seeded by SubWord(RotWord(w3)) ^ Rcon
   always_comb begin
      w0 = prev_key[127:96];
      w1 = prev_key[95:64];
      w2 = prev_key[63:32];
      w3 = prev_key[31:0];
      t  = sub_word(rot_word(w3)) ^ {get_rcon(round), 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key-schedule controller: expands one round per clock
// through a single shared round datapath, buffers all 11 round keys, streams
// each key as produced and serves registered reads by round index.
module key_schedule_ctrl
   import aes_key_pkg::*;
#(
   parameter int NR = 10,
   parameter int AW = 4
) (
   input logic             clk,
   input logic             rst,
   key_schedule_ctrl_if.slave bus
);

   localparam int         NK         = NR + 1;
   localparam logic [1:0] S_IDLE     = 2'(ST_IDLE);
   localparam logic [1:0] S_RUN      = 2'(ST_RUN);
   localparam logic [1:0] S_DONE     = 2'(ST_DONE);
   localparam logic [3:0] LAST_ROUND = 4'(NR);

   logic [1:0] state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [3:0] prev_idx;
   round_key_t key_buf_q [NK];
   round_key_t key_buf_d [NK];
   logic       key_valid_q, key_valid_d;
   round_key_t rk_out_q, rk_out_d;
   logic       rk_out_vld_q, rk_out_vld_d;
   logic [3:0] rk_out_idx_q, rk_out_idx_d;
   round_key_t rd_data_q, rd_data_d;
   round_key_t prev_key, next_key;

   // Select the previously produced round key as the datapath operand
   always_comb begin
      prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
      prev_key = key_buf_q[prev_idx];
   end

   key_round_comb u_round (
      .prev_key (prev_key),
      .round    (round_q),
      .next_key (next_key)
   );

   // FSM, round counter, buffer writes and stream outputs
   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      key_buf_d    = key_buf_q;
      key_valid_d  = key_valid_q;
      rk_out_d     = rk_out_q;
      rk_out_vld_d = 1'b0;
      rk_out_idx_d = rk_out_idx_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            round_d = 4'd0;
            if (bus.start) begin
               key_buf_d[0] = bus.key_in;
               rk_out_d     = bus.key_in;
               rk_out_idx_d = 4'd0;
               rk_out_vld_d = 1'b1;
               round_d      = 4'd1;
               key_valid_d  = 1'b0;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            key_buf_d[round_q] = next_key;
            rk_out_d           = next_key;
            rk_out_idx_d       = round_q;
            rk_out_vld_d       = 1'b1;
            if (round_q == LAST_ROUND) begin
               state_d     = S_DONE;
               key_valid_d = 1'b1;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   // Registered read port; reads see the buffer before this edge's write
   always_comb begin
      rd_data_d = '0;
      if (bus.rd_addr <= AW'(NR)) begin
         rd_data_d = key_buf_q[bus.rd_addr];
      end
   end

   // State registers; reset discards any partially built schedule
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         round_q      <= 4'd0;
         key_valid_q  <= 1'b0;
         rk_out_q     <= '0;
         rk_out_vld_q <= 1'b0;
         rk_out_idx_q <= 4'd0;
         rd_data_q    <= '0;
         for (int i = 0; i < NK; i++) begin
            key_buf_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         key_valid_q  <= key_valid_d;
         rk_out_q     <= rk_out_d;
         rk_out_vld_q <= rk_out_vld_d;
         rk_out_idx_q <= rk_out_idx_d;
         rd_data_q    <= rd_data_d;
         for (int i = 0; i < NK; i++) begin
            key_buf_q[i] <= key_buf_d[i];
         end
      end
   end

   assign bus.busy       = (state_q == S_RUN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.key_valid  = key_valid_q;
   assign bus.rk_out     = rk_out_q;
   assign bus.rk_out_vld = rk_out_vld_q;
   assign bus.rk_out_idx = rk_out_idx_q;
   assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed testbench for key_schedule_ctrl using FIPS-197 and all-zero key
// schedules as reference vectors.
module tb_key_schedule_ctrl;
   import aes_key_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   logic [127:0] fips_rk [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   logic [127:0] zero_rk [11] = '{
      128'h00000000000000000000000000000000,
      128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
      128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b,
      128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7,
      128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f,
      128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e
   };

   key_schedule_ctrl_if #(.AW(4)) bus ();

   key_schedule_ctrl #(.NR(10), .AW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Present a key with start for one accepting edge; return at the negedge
   // after acceptance. key_in is then scrambled to prove it was latched.
   task automatic launch(input logic [127:0] k, input bit hold);
      bus.start  = 1'b1;
      bus.key_in = k;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      bus.key_in = ~k;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.key_in  = '0;
      bus.rd_addr = '0;
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.done, bus.key_valid, bus.rk_out_vld, bus.rk_out_idx} !== 8'h0 ||
          bus.rk_out !== '0 || bus.rd_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b kv=%b vld=%b idx=%0d rk=%h rd=%h, want all 0",
                  bus.busy, bus.done, bus.key_valid, bus.rk_out_vld, bus.rk_out_idx, bus.rk_out, bus.rd_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fips();
      int t_accept;
      t_accept = cyc;
      launch(FIPS_KEY, 1'b0);
      for (int i = 0; i <= 10; i++) begin
         vectors++;
         if (bus.rk_out_vld !== 1'b1 || bus.rk_out_idx !== 4'(i) || bus.rk_out !== fips_rk[i]) begin
            miscompares++;
            $display("[TB] FAIL fips_stream[%0d]: got vld=%b idx=%0d rk=%h, want vld=1 idx=%0d rk=%h",
                     i, bus.rk_out_vld, bus.rk_out_idx, bus.rk_out, i, fips_rk[i]);
         end
         vectors++;
         if (bus.done !== 1'(i == 10) || bus.busy !== 1'(i < 10) || bus.key_valid !== 1'(i == 10)) begin
            miscompares++;
            $display("[TB] FAIL fips_status[%0d]: got done=%b busy=%b kv=%b, want done=%b busy=%b kv=%b",
                     i, bus.done, bus.busy, bus.key_valid, i == 10, i < 10, i == 10);
         end
         if (i < 10) @(negedge clk);
      end
      vectors++;
      if (cyc - t_accept !== 11) begin
         miscompares++;
         $display("[TB] FAIL fips_done_latency: got %0d cycles, want 11", cyc - t_accept);
      end
      @(negedge clk);
      vectors++;
      if ({bus.done, bus.busy, bus.rk_out_vld, bus.key_valid} !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL fips_idle: got done/busy/vld/kv=%b, want 0001",
                  {bus.done, bus.busy, bus.rk_out_vld, bus.key_valid});
      end
   endtask

   task automatic test_zero_readback();
      launch(ZERO_KEY, 1'b0);
      for (int i = 0; i <= 10; i++) begin
         vectors++;
         if (bus.rk_out_vld !== 1'b1 || bus.rk_out_idx !== 4'(i) || bus.rk_out !== zero_rk[i]) begin
            miscompares++;
            $display("[TB] FAIL zero_stream[%0d]: got vld=%b idx=%0d rk=%h, want vld=1 idx=%0d rk=%h",
                     i, bus.rk_out_vld, bus.rk_out_idx, bus.rk_out, i, zero_rk[i]);
         end
         @(negedge clk);
      end
      for (int a = 0; a <= 11; a++) begin
         bus.rd_addr = (a == 11) ? 4'd15 : 4'(a);
         @(negedge clk);
         vectors++;
         if (bus.rd_data !== ((a == 11) ? 128'h0 : zero_rk[a])) begin
            miscompares++;
            $display("[TB] FAIL zero_read[%0d]: got %h, want %h",
                     bus.rd_addr, bus.rd_data, (a == 11) ? 128'h0 : zero_rk[a]);
         end
      end
      bus.rd_addr = 4'd11;
      @(negedge clk);
      vectors++;
      if (bus.rd_data !== 128'h0) begin
         miscompares++;
         $display("[TB] FAIL read_addr11: got %h, want 0", bus.rd_data);
      end
   endtask

   task automatic test_start_held();
      int dones = 0;
      launch(FIPS_KEY, 1'b1);
      bus.key_in = ZERO_KEY;
      for (int i = 0; i <= 12; i++) begin
         if (bus.done === 1'b1) dones++;
         if (i <= 10) begin
            vectors++;
            if (bus.rk_out_idx !== 4'(i) || bus.rk_out !== fips_rk[i]) begin
               miscompares++;
               $display("[TB] FAIL held_stream[%0d]: got idx=%0d rk=%h, want idx=%0d rk=%h",
                        i, bus.rk_out_idx, bus.rk_out, i, fips_rk[i]);
            end
         end
         if (i == 10) bus.start = 1'b0;
         @(negedge clk);
      end
      vectors++;
      if (dones !== 1 || bus.rk_out_vld !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL held_done_count: got dones=%0d vld=%b, want dones=1 vld=0",
                  dones, bus.rk_out_vld);
      end
   endtask

   task automatic test_read_during_write();
      // Buffer currently holds the FIPS schedule; overwrite with zero key
      launch(ZERO_KEY, 1'b0);
      for (int i = 0; i <= 10; i++) begin
         if (i == 2) bus.rd_addr = 4'd3;
         if (i == 3) begin
            vectors++;
            if (bus.rd_data !== fips_rk[3]) begin
               miscompares++;
               $display("[TB] FAIL rdw_old: got %h, want %h", bus.rd_data, fips_rk[3]);
            end
         end
         if (i == 4) begin
            vectors++;
            if (bus.rd_data !== zero_rk[3]) begin
               miscompares++;
               $display("[TB] FAIL rdw_new: got %h, want %h", bus.rd_data, zero_rk[3]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int t1 = 0;
      launch(FIPS_KEY, 1'b0);
      for (int i = 0; i <= 10; i++) begin
         vectors++;
         if (bus.rk_out !== fips_rk[i]) begin
            miscompares++;
            $display("[TB] FAIL b2b_first[%0d]: got %h, want %h", i, bus.rk_out, fips_rk[i]);
         end
         if (i < 10) @(negedge clk);
      end
      t1 = cyc;
      launch(ZERO_KEY, 1'b0);
      vectors++;
      if (bus.key_valid !== 1'b0 || bus.busy !== 1'b1 || bus.rk_out_idx !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL b2b_accept: got kv=%b busy=%b idx=%0d, want kv=0 busy=1 idx=0",
                  bus.key_valid, bus.busy, bus.rk_out_idx);
      end
      for (int i = 0; i <= 10; i++) begin
         vectors++;
         if (bus.rk_out !== zero_rk[i] || bus.rk_out_idx !== 4'(i) || bus.done !== 1'(i == 10)) begin
            miscompares++;
            $display("[TB] FAIL b2b_second[%0d]: got rk=%h idx=%0d done=%b, want rk=%h idx=%0d done=%b",
                     i, bus.rk_out, bus.rk_out_idx, bus.done, zero_rk[i], i, i == 10);
         end
         if (i < 10) @(negedge clk);
      end
      vectors++;
      if (cyc - t1 !== 11) begin
         miscompares++;
         $display("[TB] FAIL b2b_spacing: got %0d cycles, want 11", cyc - t1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      launch(FIPS_KEY, 1'b0);
      for (int i = 0; i < 5; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.key_valid, bus.rk_out_vld, bus.rk_out_idx} !== 8'h0 ||
          bus.rk_out !== '0 || bus.rd_data !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrun_reset: got busy=%b done=%b kv=%b vld=%b idx=%0d rk=%h rd=%h, want all 0",
                  bus.busy, bus.done, bus.key_valid, bus.rk_out_vld, bus.rk_out_idx, bus.rk_out, bus.rd_data);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a <= 10; a++) begin
         bus.rd_addr = 4'(a);
         @(negedge clk);
         vectors++;
         if (bus.rd_data !== 128'h0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrun_cleared[%0d]: got rd=%h done=%b, want rd=0 done=0",
                     a, bus.rd_data, bus.done);
         end
      end
      launch(FIPS_KEY, 1'b0);
      for (int i = 0; i <= 10; i++) begin
         vectors++;
         if (bus.rk_out !== fips_rk[i] || bus.done !== 1'(i == 10)) begin
            miscompares++;
            $display("[TB] FAIL post_reset[%0d]: got rk=%h done=%b, want rk=%h done=%b",
                     i, bus.rk_out, bus.done, fips_rk[i], i == 10);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_zero_readback();
      test_start_held();
      test_read_during_write();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
